// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider between N_REQ requesters.
// Optional `DIV_ARB_ZERO_BYPASS_EN: zero divisors skip the divider and return all-ones/dividend.
module div_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DIVIDEND_W = 64,
    parameter int DIVISOR_W  = 32,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DIVIDEND_W-1:0]   req_dividend,
    input  logic [N_REQ*DIVISOR_W-1:0]    req_divisor,
    output logic [N_REQ-1:0]              gnt,
    output logic [N_REQ-1:0]              rsp_valid,
    input  logic [N_REQ-1:0]              rsp_ack,
    output logic [DIVISOR_W-1:0]          rsp_quotient,
    output logic [DIVIDEND_W-1:0]         rsp_remainder,
    output logic                          busy,
    output logic                          div_start,
    output logic                          div_ack,
    output logic [DIVIDEND_W-1:0]         div_dividend,
    output logic [DIVISOR_W-1:0]          div_divisor,
    input  logic [DIVISOR_W-1:0]          div_quotient,
    input  logic [DIVIDEND_W-1:0]         div_remainder
`ifdef DIV_ARB_ZERO_BYPASS_EN
    ,
    output logic                          div_by_zero
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // IDLE arbitrate | START gnt+div_start | WAIT count latency | RESP hold result | DONE div_ack
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_owner;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_found;
    logic [IDX_W-1:0]      w_win;
    logic [N_REQ-1:0]      w_win_oh;
    logic [DIVIDEND_W-1:0] w_sel_dividend;
    logic [DIVISOR_W-1:0]  w_sel_divisor;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
        w_win_oh       = N_REQ'(1) << w_win;
        w_sel_dividend = req_dividend[w_win*DIVIDEND_W +: DIVIDEND_W];
        w_sel_divisor  = req_divisor[w_win*DIVISOR_W +: DIVISOR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_cnt         <= '0;
            gnt           <= '0;
            rsp_valid     <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            busy          <= 1'b0;
            div_start     <= 1'b0;
            div_ack       <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            div_by_zero   <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            div_start <= 1'b0;
            div_ack   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner      <= w_win;
                        div_dividend <= w_sel_dividend;
                        div_divisor  <= w_sel_divisor;
                        gnt          <= w_win_oh;
                        busy         <= 1'b1;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                        if (w_sel_divisor == '0) begin
                            rsp_quotient  <= '1;
                            rsp_remainder <= w_sel_dividend;
                            rsp_valid     <= w_win_oh;
                            div_by_zero   <= 1'b1;
                            r_state       <= S_RESP;
                        end else begin
                            div_start <= 1'b1;
                            r_state   <= S_START;
                        end
`else
                        div_start <= 1'b1;
                        r_state   <= S_START;
`endif
                    end
                end
                S_START: begin
                    r_cnt   <= CNT_W'(DIV_CYCLES - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Capture on the edge where the counter steps to zero.
                    if (r_cnt <= CNT_W'(1)) begin
                        r_cnt         <= '0;
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_valid     <= N_REQ'(1) << r_owner;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ack[r_owner]) begin
                        rsp_valid <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                        div_ack     <= ~div_by_zero;
                        div_by_zero <= 1'b0;
`else
                        div_ack     <= 1'b1;
`endif
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ptr   <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter with a fixed-latency divider model.
// Covers bypass behaviour when DIV_ARB_ZERO_BYPASS_EN is defined.
module tb_div_arbiter;

    localparam int NR = 2;
    localparam int DW = 64;
    localparam int SW = 32;
    localparam int DC = 33;
    localparam int CW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_dividend;
    logic [NR*SW-1:0]  req_divisor;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ack;
    logic [SW-1:0]     rsp_quotient;
    logic [DW-1:0]     rsp_remainder;
    logic              busy;
    logic              div_start;
    logic              div_ack;
    logic [DW-1:0]     div_dividend;
    logic [SW-1:0]     div_divisor;
    logic [SW-1:0]     div_quotient;
    logic [DW-1:0]     div_remainder;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    logic              div_by_zero;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    div_arbiter #(.N_REQ(NR), .DIVIDEND_W(DW), .DIVISOR_W(SW), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .busy(busy), .div_start(div_start), .div_ack(div_ack),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
        .div_remainder(div_remainder)
`ifdef DIV_ARB_ZERO_BYPASS_EN
        , .div_by_zero(div_by_zero)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: result only becomes valid DC-1 edges after div_start is sampled.
    int          dcnt = 0;
    logic [63:0] mq, mr;
    always @(posedge clk) begin
        if (rst || div_ack)  dcnt <= 0;
        else if (div_start)  dcnt <= 1;
        else if (dcnt != 0)  dcnt <= dcnt + 1;
    end
    always_comb begin
        if (div_divisor == '0) begin
            mq = '1;
            mr = div_dividend;
        end else begin
            mq = div_dividend / {32'd0, div_divisor};
            mr = div_dividend % {32'd0, div_divisor};
        end
    end
    assign div_quotient  = (dcnt >= DC - 1) ? mq[31:0] : 32'hDEAD_BEEF;
    assign div_remainder = (dcnt >= DC - 1) ? mr : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [63:0] dd, input logic [31:0] ds);
        req_dividend[i*DW +: DW] = dd;
        req_divisor[i*SW +: SW]  = ds;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        rsp_ack = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic ack_rsp(input logic [NR-1:0] a);
        rsp_ack = a;
        @(negedge clk);
        rsp_ack = '0;
    endtask

    initial begin
        int n;
        int last;
        int ok;
        req_dividend = '0;
        req_divisor  = '0;

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_start", div_start, 0);
        chk("rst_q", rsp_quotient, 0);
        chk("rst_dd", div_dividend, 0);

        // Single request 10/3
        set_op(0, 10, 3);
        req = 2'b01;
        wait_gnt(n);
        chk("t1_gnt_lat", n, 1);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_start", div_start, 1);
        chk("t1_dd", div_dividend, 10);
        chk("t1_ds", div_divisor, 3);
        chk("t1_busy", busy, 1);
        req = '0;
        wait_rsp(n);
        chk("t1_rsp_lat", n, DC);
        chk("t1_valid", rsp_valid, 2'b01);
        chk("t1_q", rsp_quotient, 3);
        chk("t1_r", rsp_remainder, 1);
        ack_rsp(2'b01);
        chk("t1_div_ack", div_ack, 1);
        chk("t1_valid_drop", rsp_valid, 0);
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_ack_pulse", div_ack, 0);

        // Simultaneous requests
        do_reset();
        set_op(0, 100, 7);
        set_op(1, 64, 8);
        req = 2'b11;
        wait_gnt(n);
        chk("t2_first", gnt, 2'b01);
        req = 2'b10;
        wait_rsp(n);
        chk("t2_valid0", rsp_valid, 2'b01);
        chk("t2_q0", rsp_quotient, 14);
        chk("t2_r0", rsp_remainder, 2);
        ack_rsp(2'b01);
        wait_gnt(n);
        chk("t2_second", gnt, 2'b10);
        req = '0;
        wait_rsp(n);
        chk("t2_valid1", rsp_valid, 2'b10);
        chk("t2_q1", rsp_quotient, 8);
        chk("t2_r1", rsp_remainder, 0);
        ack_rsp(2'b10);

        // Fairness with both held high
        do_reset();
        set_op(0, 20, 4);
        set_op(1, 21, 4);
        req  = 2'b11;
        last = 0;
        for (int i = 0; i < 6; i++) begin
            wait_gnt(n);
            chk("fair_owner", gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
            if (i > 0) chk("fair_spacing", cyc - last, DC + 3);
            last = cyc;
            wait_rsp(n);
            chk("fair_r", rsp_remainder, (i % 2 == 1) ? 1 : 0);
            ack_rsp(rsp_valid);
        end
        req = '0;

        // Delayed ack with a pending competitor
        do_reset();
        set_op(0, 200, 9);
        req = 2'b01;
        wait_gnt(n);
        set_op(1, 50, 5);
        req = 2'b10;
        wait_rsp(n);
        chk("t4_q", rsp_quotient, 22);
        chk("t4_r", rsp_remainder, 2);
        rsp_ack = 2'b10;
        ok = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid == 2'b01 && rsp_quotient == 22 && rsp_remainder == 2 && gnt == '0) ok++;
        end
        chk("t4_hold", ok, 20);
        ack_rsp(2'b01);
        chk("t4_div_ack", div_ack, 1);
        wait_gnt(n);
        chk("t4_gnt_lat", n, 2);
        chk("t4_gnt", gnt, 2'b10);
        req = '0;
        wait_rsp(n);
        chk("t4_q1", rsp_quotient, 10);
        ack_rsp(2'b10);

        // Reset in the 10th WAIT cycle
        do_reset();
        set_op(0, 10, 3);
        req = 2'b01;
        wait_gnt(n);
        req = '0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_dd", div_dividend, 0);
        chk("t5_ds", div_divisor, 0);
        chk("t5_outs", {gnt, rsp_valid, div_start, div_ack}, 0);
        rst = 1'b0;
        set_op(1, 64, 8);
        req = 2'b10;
        wait_gnt(n);
        chk("t5_gnt_lat", n, 1);
        chk("t5_gnt", gnt, 2'b10);
        req = '0;
        wait_rsp(n);
        chk("t5_q", rsp_quotient, 8);
        ack_rsp(2'b10);

`ifdef DIV_ARB_ZERO_BYPASS_EN
        do_reset();
        set_op(0, 55, 0);
        req = 2'b01;
        wait_gnt(n);
        req = '0;
        chk("bz_gnt", gnt, 2'b01);
        chk("bz_start", div_start, 0);
        chk("bz_valid", rsp_valid, 2'b01);
        chk("bz_q", rsp_quotient, 32'hFFFF_FFFF);
        chk("bz_r", rsp_remainder, 55);
        chk("bz_flag", div_by_zero, 1);
        ack_rsp(2'b01);
        chk("bz_no_ack", div_ack, 0);
        chk("bz_flag_clr", div_by_zero, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin scheduler that shares one multi-cycle `div` unit between N_REQ requesters.
- Arbitrates requests and latches the winner's operands.
- Sequences the divider's start/ack handshake and counts its fixed iteration latency.
- Returns quotient/remainder to the owning requester through a valid/ack response handshake.
- Sits between the execute-stage requesters (integer pipe, mult/div unit) and the single `div` instance.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DIVIDEND_W, 64, dividend and remainder width
- DIVISOR_W, 32, divisor and quotient width
- DIV_CYCLES, 33, cycles from the div_start cycle until div_quotient/div_remainder are valid
- CNT_W, 6, latency counter width; must satisfy 2^CNT_W > DIV_CYCLES

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req  in  N_REQ  per-requester request
- req_dividend  in  N_REQ*DIVIDEND_W  packed dividends; requester i at [i*DIVIDEND_W +: DIVIDEND_W]
- req_divisor  in  N_REQ*DIVISOR_W  packed divisors, same packing
- gnt  out  N_REQ  one-hot grant pulse; operands have been captured
- rsp_valid  out  N_REQ  one-hot result valid to the owning requester
- rsp_ack  in  N_REQ  per-requester result acknowledge
- rsp_quotient  out  DIVISOR_W  result quotient, shared by all requesters
- rsp_remainder  out  DIVIDEND_W  result remainder, shared by all requesters
- busy  out  1  high in every state except IDLE
- div_start  out  1  divider start pulse
- div_ack  out  1  divider acknowledge pulse; returns the divider to idle
- div_dividend  out  DIVIDEND_W  latched dividend to the divider
- div_divisor  out  DIVISOR_W  latched divisor to the divider
- div_quotient  in  DIVISOR_W  divider quotient
- div_remainder  in  DIVIDEND_W  divider remainder

Behaviour:
- Reset (synchronous): state=IDLE; rr pointer=0; all outputs 0, including latched operands and results.
  - A reset in any state aborts the operation; no div_ack is issued, since the divider shares rst.
- IDLE:
  - If |req, select the winner W: first asserted req at or after the rr pointer, wrapping modulo N_REQ.
  - Latch req_dividend[W] and req_divisor[W] into div_dividend/div_divisor; record owner=W; go to START.
  - If no req, stay in IDLE.
- START (1 cycle):
  - gnt[owner]=1 and div_start=1.
  - Load counter with DIV_CYCLES-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture div_quotient/div_remainder into rsp_quotient/rsp_remainder; go to RESP.
- RESP:
  - rsp_valid[owner]=1; results held stable.
  - Stay until rsp_ack[owner]=1, then go to DONE.
  - rsp_ack on a non-owner bit is ignored; rsp_ack may be high in the first RESP cycle.
- DONE (1 cycle):
  - div_ack=1; rsp_valid=0.
  - rr pointer=(owner+1) mod N_REQ; go to IDLE.
- Latency:
  - req sampled in IDLE at edge E0 → gnt/div_start high in cycle E0..E1.
  - rsp_valid rises DIV_CYCLES cycles after the div_start cycle.
  - Minimum spacing between successive grants is DIV_CYCLES+3 cycles.
- Requester rules:
  - Hold req and operands stable until gnt is seen; drop req in the cycle after gnt, or keep it high to queue another divide.
  - A req dropped before grant is simply not serviced.
  - Operands changing after capture have no effect.
- gnt, div_start and div_ack are each exactly one cycle wide; gnt and rsp_valid are always one-hot or zero.
- Simultaneous requests: strict rr order. With all N_REQ requesting continuously, each is served once per N_REQ operations.
- Outputs are registered; no combinational path from req or rsp_ack to any output.

Optional Feature:
- Macro: DIV_ARB_ZERO_BYPASS_EN.
- Enabled:
  - In IDLE, if the winner's divisor==0, skip START and WAIT: gnt[W]=1 that cycle, no div_start.
  - Load rsp_quotient={DIVISOR_W{1'b1}} and rsp_remainder=dividend; go directly to RESP.
  - Go DONE→IDLE without div_ack.
  - Add output div_by_zero (1 bit), high alongside rsp_valid for bypassed operations.
- Disabled:
  - Zero divisors go through the divider like any other operand, with its result passed through.
  - No div_by_zero port.

Test Plan:
- Single request, N_REQ=2, DIV_CYCLES=33:
  - req[0] with 10/3 → gnt[0] and div_start one cycle after sampling.
  - rsp_valid[0] 33 cycles later with quotient=3, remainder=1.
  - rsp_ack[0] → div_ack pulse, busy low the next cycle.
- Simultaneous requests:
  - req=2'b11 after reset, with 100/7 and 64/8 → requester 0 served first (14 r 2), then requester 1 (8 r 0).
  - No overlap of rsp_valid bits.
- Fairness: both requesters held high for 6 operations → grant order 0,1,0,1,0,1.
- Delayed ack: rsp_ack[0] withheld 20 cycles → rsp_valid[0] and the results stay constant.
  - No new gnt until DONE, even though req[1] is pending.
- Reset mid-WAIT: assert rst at the 10th WAIT cycle.
  - Next cycle all outputs are 0 and state is IDLE.
  - A following req[1] is granted first (pointer reset to 0, but req[0] is not asserted).
- Zero divisor with DIV_ARB_ZERO_BYPASS_EN: 55/0 → no div_start.
  - rsp_valid next cycle with quotient=32'hFFFFFFFF, remainder=55, div_by_zero=1.
